// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller producing per-stage enables/bubbles and ID operand forwarding selects
// for the 5-stage MIPS core (RAW, load-use, branch, memory-wait and debug-step handling).
module hazard_ctrl #(
    parameter int FWD_EN         = 1,
    parameter int BRANCH_MODE    = 0,
    parameter int BRANCH_BUBBLES = 3,
    parameter int MEM_TIMEOUT    = 255,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             debug_en,
    input  logic             debug_step,
    input  logic [4:0]       rs_addr_id,
    input  logic [4:0]       rt_addr_id,
    input  logic             rs_used_id,
    input  logic             rt_used_id,
    input  logic             is_branch_id,
    input  logic             branch_taken_exe,
    input  logic [4:0]       regw_addr_exe,
    input  logic [4:0]       regw_addr_mem,
    input  logic [4:0]       regw_addr_wb,
    input  logic             wb_wen_exe,
    input  logic             wb_wen_mem,
    input  logic             wb_wen_wb,
    input  logic             mem_ren_exe,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic [4:0]       stage_en,
    output logic [4:0]       stage_rst,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int WW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] TO_M1 = WW'(MEM_TIMEOUT - 1);
    localparam logic [2:0] BUB_LD = 3'(BRANCH_BUBBLES - 1);
    localparam bit FWD = FWD_EN != 0;
    localparam bit BM1 = BRANCH_MODE != 0;

    logic          r_step_prev;
    logic [2:0]    r_bub_cnt;
    logic [WW-1:0] r_wait_cnt;
    logic          r_mem_timeout;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    logic w_ex_a, w_mem_a, w_wb_a, w_ex_b, w_mem_b, w_wb_b;
    logic w_hz, w_step, w_dbg, w_frz, w_fl, w_st, w_bub;
    logic [1:0] w_sel_a, w_sel_b;

    assign w_ex_a  = rs_used_id && rs_addr_id != 5'd0 && wb_wen_exe && regw_addr_exe == rs_addr_id;
    assign w_mem_a = rs_used_id && rs_addr_id != 5'd0 && wb_wen_mem && regw_addr_mem == rs_addr_id;
    assign w_wb_a  = rs_used_id && rs_addr_id != 5'd0 && wb_wen_wb  && regw_addr_wb  == rs_addr_id;
    assign w_ex_b  = rt_used_id && rt_addr_id != 5'd0 && wb_wen_exe && regw_addr_exe == rt_addr_id;
    assign w_mem_b = rt_used_id && rt_addr_id != 5'd0 && wb_wen_mem && regw_addr_mem == rt_addr_id;
    assign w_wb_b  = rt_used_id && rt_addr_id != 5'd0 && wb_wen_wb  && regw_addr_wb  == rt_addr_id;

    assign w_sel_a = w_ex_a ? 2'd1 : w_mem_a ? 2'd2 : w_wb_a ? 2'd3 : 2'd0;
    assign w_sel_b = w_ex_b ? 2'd1 : w_mem_b ? 2'd2 : w_wb_b ? 2'd3 : 2'd0;
    assign fwd_a_sel = (FWD && rst_n) ? w_sel_a : 2'd0;
    assign fwd_b_sel = (FWD && rst_n) ? w_sel_b : 2'd0;

    // Without forwarding only EXE/MEM producers stall; WB is assumed to write through the register file
    assign w_hz = FWD ? (mem_ren_exe && (w_ex_a || w_ex_b)) : (w_ex_a || w_ex_b || w_mem_a || w_mem_b);

    assign w_step = debug_step && !r_step_prev;
    assign w_dbg  = debug_en && !w_step;
    assign w_frz  = !w_dbg && mem_req && !mem_ack;
    assign w_fl   = !w_dbg && !w_frz && BM1 && branch_taken_exe;
    assign w_st   = !w_dbg && !w_frz && !w_fl && w_hz;
    assign w_bub  = !w_dbg && !w_frz && !w_fl && !w_st && !BM1 && (r_bub_cnt != 3'd0 || is_branch_id);

    always_comb begin
        stage_en  = 5'b11111;
        stage_rst = 5'b00000;
        if (!rst_n) stage_rst = 5'b11111;
        else if (w_dbg || w_frz) stage_en = 5'b00000;
        else if (w_fl) stage_rst = 5'b00110;
        else if (w_st) begin
            stage_en  = 5'b11100;
            stage_rst = 5'b00100;
        end
        else if (w_bub) stage_rst = 5'b00010;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_prev   <= 1'b0;
            r_bub_cnt     <= 3'd0;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
        end else begin
            r_step_prev <= debug_step;
            if (w_bub) r_bub_cnt <= (is_branch_id && r_bub_cnt == 3'd0) ? BUB_LD : r_bub_cnt - 3'd1;
            r_wait_cnt <= w_frz ? r_wait_cnt + WW'(r_wait_cnt != '1) : '0;
            if (w_frz && r_wait_cnt >= TO_M1) r_mem_timeout <= 1'b1;
            r_stall_cnt <= r_stall_cnt + CNT_W'(w_st && r_stall_cnt != '1);
            r_flush_cnt <= r_flush_cnt + CNT_W'((w_fl || w_bub) && r_flush_cnt != '1);
        end
    end

    assign mem_timeout = r_mem_timeout;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl in three configurations
// (u0: forwarding + bubble mode, u1: flush mode, u2: forwarding disabled).
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic debug_en, debug_step, rs_used, rt_used, is_branch, taken;
    logic wen_exe, wen_mem, wen_wb, mem_ren, mem_req, mem_ack;
    logic [4:0] rs, rt, wa_exe, wa_mem, wa_wb;

    logic [4:0]  en0, rst0, en1, rst1, en2, rst2;
    logic [1:0]  fa0, fb0, fa1, fb1, fa2, fb2;
    logic        to0, to1, to2;
    logic [15:0] sc0, fc0, sc1, fc1, sc2, fc2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.FWD_EN(1), .BRANCH_MODE(0), .BRANCH_BUBBLES(3), .MEM_TIMEOUT(4), .CNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .debug_en(debug_en), .debug_step(debug_step),
        .rs_addr_id(rs), .rt_addr_id(rt), .rs_used_id(rs_used), .rt_used_id(rt_used),
        .is_branch_id(is_branch), .branch_taken_exe(taken),
        .regw_addr_exe(wa_exe), .regw_addr_mem(wa_mem), .regw_addr_wb(wa_wb),
        .wb_wen_exe(wen_exe), .wb_wen_mem(wen_mem), .wb_wen_wb(wen_wb),
        .mem_ren_exe(mem_ren), .mem_req(mem_req), .mem_ack(mem_ack),
        .stage_en(en0), .stage_rst(rst0), .fwd_a_sel(fa0), .fwd_b_sel(fb0),
        .mem_timeout(to0), .stall_cnt(sc0), .flush_cnt(fc0));

    hazard_ctrl #(.FWD_EN(1), .BRANCH_MODE(1), .BRANCH_BUBBLES(3), .MEM_TIMEOUT(4), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .debug_en(debug_en), .debug_step(debug_step),
        .rs_addr_id(rs), .rt_addr_id(rt), .rs_used_id(rs_used), .rt_used_id(rt_used),
        .is_branch_id(is_branch), .branch_taken_exe(taken),
        .regw_addr_exe(wa_exe), .regw_addr_mem(wa_mem), .regw_addr_wb(wa_wb),
        .wb_wen_exe(wen_exe), .wb_wen_mem(wen_mem), .wb_wen_wb(wen_wb),
        .mem_ren_exe(mem_ren), .mem_req(mem_req), .mem_ack(mem_ack),
        .stage_en(en1), .stage_rst(rst1), .fwd_a_sel(fa1), .fwd_b_sel(fb1),
        .mem_timeout(to1), .stall_cnt(sc1), .flush_cnt(fc1));

    hazard_ctrl #(.FWD_EN(0), .BRANCH_MODE(0), .BRANCH_BUBBLES(3), .MEM_TIMEOUT(4), .CNT_W(16)) u2 (
        .clk(clk), .rst_n(rst_n), .debug_en(debug_en), .debug_step(debug_step),
        .rs_addr_id(rs), .rt_addr_id(rt), .rs_used_id(rs_used), .rt_used_id(rt_used),
        .is_branch_id(is_branch), .branch_taken_exe(taken),
        .regw_addr_exe(wa_exe), .regw_addr_mem(wa_mem), .regw_addr_wb(wa_wb),
        .wb_wen_exe(wen_exe), .wb_wen_mem(wen_mem), .wb_wen_wb(wen_wb),
        .mem_ren_exe(mem_ren), .mem_req(mem_req), .mem_ack(mem_ack),
        .stage_en(en2), .stage_rst(rst2), .fwd_a_sel(fa2), .fwd_b_sel(fb2),
        .mem_timeout(to2), .stall_cnt(sc2), .flush_cnt(fc2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        debug_en = 0; debug_step = 0; rs_used = 0; rt_used = 0; is_branch = 0; taken = 0;
        wen_exe = 0; wen_mem = 0; wen_wb = 0; mem_ren = 0; mem_req = 0; mem_ack = 0;
        rs = 0; rt = 0; wa_exe = 0; wa_mem = 0; wa_wb = 0;
    endtask

    // advance to just after the next rising edge, inputs are then changed mid-cycle
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        clr();
        rst_n = 0;
        rs_used = 1; rs = 5'd3; wa_exe = 5'd3; wen_exe = 1;
        #3;
        chk("rst_stage_rst", rst0, 5'b11111);
        chk("rst_stage_en", en0, 5'b11111);
        chk("rst_fwd_a", fa0, 2'd0);
        chk("rst_timeout", to0, 1'b0);
        chk("rst_stall_cnt", sc0, 16'd0);
        chk("rst_flush_cnt", fc0, 16'd0);
        @(negedge clk) rst_n = 1;

        // EXE forward, no stall
        cyc(); #1;
        chk("exe_fwd_a", fa0, 2'd1);
        chk("exe_fwd_en", en0, 5'b11111);
        chk("exe_fwd_rst", rst0, 5'b00000);
        chk("nofwd_stall_en", en2, 5'b11100);
        chk("nofwd_stall_rst", rst2, 5'b00100);
        chk("nofwd_sel", fa2, 2'd0);
        // EXE beats MEM
        cyc(); wa_mem = 5'd3; wen_mem = 1; #1;
        chk("exe_over_mem", fa0, 2'd1);
        // MEM beats WB
        cyc(); wen_exe = 0; wa_wb = 5'd3; wen_wb = 1; #1;
        chk("mem_over_wb", fa0, 2'd2);
        // WB only; no-forward config ignores WB
        cyc(); wen_mem = 0; #1;
        chk("wb_fwd", fa0, 2'd3);
        chk("nofwd_wb_en", en2, 5'b11111);
        // $0 never hazards
        cyc(); rs = 5'd0; wa_wb = 5'd0; wa_exe = 5'd0; wen_exe = 1; #1;
        chk("zero_reg", fa0, 2'd0);

        // load-use
        cyc(); clr(); rt_used = 1; rt = 5'd4; wa_exe = 5'd4; wen_exe = 1; mem_ren = 1; #1;
        chk("lu_en", en0, 5'b11100);
        chk("lu_rst", rst0, 5'b00100);
        chk("lu_fwd_b", fb0, 2'd1);
        cyc(); wen_exe = 0; mem_ren = 0; wa_mem = 5'd4; wen_mem = 1; #1;
        chk("lu_next_fwd_b", fb0, 2'd2);
        chk("lu_next_en", en0, 5'b11111);
        chk("lu_stall_cnt", sc0, 16'd1);

        // mode 0 branch bubbles
        cyc(); clr(); is_branch = 1; #1;
        chk("br_bub0", rst0, 5'b00010);
        chk("br_bub0_en", en0, 5'b11111);
        chk("br_mode1_nobub", rst1, 5'b00000);
        cyc(); is_branch = 0; #1;
        chk("br_bub1", rst0, 5'b00010);
        cyc(); #1;
        chk("br_bub2", rst0, 5'b00010);
        cyc(); #1;
        chk("br_done", rst0, 5'b00000);
        chk("br_flush_cnt", fc0, 16'd3);

        // mode 1 flush overrides load-use stall
        cyc(); taken = 1; rt_used = 1; rt = 5'd4; wa_exe = 5'd4; wen_exe = 1; mem_ren = 1; #1;
        chk("fl_rst", rst1, 5'b00110);
        chk("fl_en", en1, 5'b11111);
        chk("fl_mode0_stall", en0, 5'b11100);
        cyc(); clr(); #1;
        chk("fl_flush_cnt", fc1, 16'd1);
        chk("fl_stall_cnt", sc1, 16'd1);
        chk("m0_stall_cnt", sc0, 16'd2);

        // memory wait timeout at 4
        cyc(); mem_req = 1; #1;
        chk("mw1_en", en0, 5'b00000);
        chk("mw1_to", to0, 1'b0);
        cyc(); cyc(); cyc(); #1;
        chk("mw4_en", en0, 5'b00000);
        chk("mw4_to", to0, 1'b0);
        cyc(); #1;
        chk("mw5_to", to0, 1'b1);
        chk("mw5_en", en0, 5'b00000);
        cyc(); mem_ack = 1; #1;
        chk("mw_ack_en", en0, 5'b11111);
        cyc(); clr(); #1;
        chk("to_sticky", to0, 1'b1);
        rst_n = 0; #1;
        chk("to_async_clr", to0, 1'b0);
        chk("async_stall_clr", sc0, 16'd0);
        @(negedge clk) rst_n = 1;

        // reset mid-bubble: first cycle after release is normal
        cyc(); is_branch = 1; #1;
        chk("rb_bub", rst0, 5'b00010);
        cyc(); is_branch = 0; #1;
        rst_n = 0; #1;
        @(negedge clk) rst_n = 1;
        cyc(); #1;
        chk("rb_after_rst", rst0, 5'b00000);

        // debug single step with step held high
        cyc(); debug_en = 1; #1;
        chk("dbg_hold", en0, 5'b00000);
        cyc(); debug_step = 1; #1;
        chk("dbg_step", en0, 5'b11111);
        cyc(); #1;
        chk("dbg_held1", en0, 5'b00000);
        cyc(); #1;
        chk("dbg_held2", en0, 5'b00000);
        cyc(); debug_step = 0; #1;
        chk("dbg_release", en0, 5'b00000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage MIPS CPU. It produces the per-stage enable/reset vectors and the operand-forwarding selects for the ID-stage operands. It handles:
- RAW hazards, by forwarding or by stalling;
- load-use stalls;
- branch bubbles or branch flushes;
- data-memory wait freezes with a timeout;
- debug single-step.

It sits beside the decoder in ID. It is driven by ID decode results and by EXE/MEM/WB writeback feedback.

## Interface
- FWD_EN, 1: 1 enables forwarding; 0 stalls on every RAW hazard with EXE/MEM.
- BRANCH_MODE, 0: 0 inserts fixed bubbles after every branch; 1 predicts not-taken and flushes on `branch_taken_exe`.
- BRANCH_BUBBLES, 3: number of bubbles in mode 0, range 1..7.
- MEM_TIMEOUT, 255: consecutive wait cycles before `mem_timeout` is set.
- CNT_W, 16: width of the performance counters.

Ports (clock and reset first):
- clk  in  1  main clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- debug_en  in  1  debug suspend mode.
- debug_step  in  1  step request (level; its rising edge is used).
- rs_addr_id, rt_addr_id  in  5  source register addresses in ID.
- rs_used_id, rt_used_id  in  1  source register is read.
- is_branch_id  in  1  ID holds a jump/branch.
- branch_taken_exe  in  1  EXE branch resolved taken (mode 1 only).
- regw_addr_exe/mem/wb  in  5  destination address per stage.
- wb_wen_exe/mem/wb  in  1  register write enable per stage.
- mem_ren_exe  in  1  EXE holds a load.
- mem_req  in  1  MEM stage is accessing data memory.
- mem_ack  in  1  data memory completes this cycle.
- stage_en  out  5  bit0=IF, bit1=ID, bit2=EXE, bit3=MEM, bit4=WB.
- stage_rst  out  5  same bit order; loads a bubble.
- fwd_a_sel, fwd_b_sel  out  2  0 = register file, 1 = EXE, 2 = MEM, 3 = WB.
- mem_timeout  out  1  sticky memory-timeout flag.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

## Operation
- Defaults: `stage_en`=5'b11111, `stage_rst`=0, selects=0.
- Register state: `step_prev`, `bub_cnt` (3 bit), `wait_cnt`, `mem_timeout`, `stall_cnt`, `flush_cnt`.
- Hazard match: a source is hazarded by stage X when the source is used, its address is nonzero, `wb_wen_X`=1 and `regw_addr_X` equals it.
- FWD_EN=1:
  - Source select priority is EXE(1), then MEM(2), then WB(3), then 0.
  - A hazard with EXE while `mem_ren_exe`=1 is a load-use: `hz_stall`=1.
  - WB forwarding applies only when no EXE or MEM match exists.
- FWD_EN=0: selects stay 0; `hz_stall`=1 on any EXE or MEM hazard; WB hazards are ignored.
- Actions, highest priority first:
  1. Reset: `stage_rst`=5'b11111.
  2. Debug hold: when `debug_en` and no step pulse, `stage_en`=0. The step pulse is `debug_step` & ~`step_prev`.
  3. Memory freeze: when `mem_req` & ~`mem_ack`, `stage_en`=0.
  4. Mode 1 flush: when `branch_taken_exe`, `stage_rst[1]`=`stage_rst[2]`=1. This overrides `hz_stall`.
  5. Hazard stall: when `hz_stall`, `stage_en[0]`=`stage_en[1]`=0 and `stage_rst[2]`=1.
  6. Mode 0 bubbles: when `bub_cnt`≠0 or `is_branch_id`, `stage_rst[1]`=1.
- `bub_cnt` (mode 0):
  - Loads BRANCH_BUBBLES-1 when action 6 fires with `is_branch_id`=1 and `bub_cnt`=0.
  - Otherwise decrements when action 6 fires.
  - Holds whenever a higher-priority action applies.
- `wait_cnt`:
  - Increments, saturating, each cycle of action 3.
  - Clears on any cycle without a wait.
  - Reaching MEM_TIMEOUT sets `mem_timeout`, which stays set until reset. The freeze continues after the timeout.
- `stall_cnt` increments on cycles where action 5 is applied. `flush_cnt` increments on cycles where action 4 or 6 is applied. Both saturate at all-ones.
- Forwarding selects are computed regardless of which action applies.

## Timing
- `stage_en`, `stage_rst` and the selects are combinational from inputs and state, with zero latency.
- All registers update on the `clk` rising edge.
- While `rst_n`=0, all registers clear immediately (asynchronous). Outputs during reset: `stage_rst`=5'b11111, `stage_en`=5'b11111, selects=0, `mem_timeout`=0, counters=0.
- Load-use stall lasts exactly 1 cycle: the load moves to MEM and then forwards via select 2.
- A mode 0 branch yields BRANCH_BUBBLES consecutive `stage_rst[1]` cycles, counting the branch's own ID cycle, provided no freeze intervenes.
- Debug: exactly one enabled cycle per rising edge of `debug_step`. A held-high step does not repeat.
- Reset asserted mid-freeze or mid-bubble clears `bub_cnt` and `wait_cnt`; the first cycle after reset release is normal.

## Test plan
- FWD_EN=1; EXE writes $3 (not a load); ID reads rs=$3 -> `fwd_a_sel`=1, `stage_en`=5'b11111, no stall.
- FWD_EN=1; EXE load to $4; ID reads rt=$4 -> 1 cycle with `stage_en`=5'b11100 and `stage_rst[2]`=1; next cycle `fwd_b_sel`=2; `stall_cnt`=1.
- Mode 0, BRANCH_BUBBLES=3, `is_branch_id` pulse -> `stage_rst[1]`=1 for 3 cycles; `flush_cnt`=3.
- Mode 1, `branch_taken_exe`=1 with `hz_stall` also true -> `stage_rst`=5'b00110, `stage_en`=5'b11111.
- MEM_TIMEOUT=4; `mem_req`=1 and `mem_ack`=0 held -> `stage_en`=0 throughout; `mem_timeout` rises after the 4th wait cycle; `rst_n` low clears it asynchronously.
- `debug_en`=1; `debug_step` held high for 3 cycles -> exactly 1 cycle with `stage_en`=5'b11111.
